// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: synchronizes and filters the raw PS/2 lines, deframes scan-code bytes,
// and resolves E0/F0 prefixes into held-key flags, press pulses and the last make code.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        PS2Clk,
  input  logic        PS2Data,
  output logic        key_up,
  output logic        key_down,
  output logic        key_left,
  output logic        key_right,
  output logic        space_held,
  output logic        start_pressed,
  output logic        space_pressed,
  output logic [15:0] keycode,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // index 0..3 = up, down, left, right (all E0-prefixed)
  localparam logic [3:0][7:0] ARROW_CODES = {8'h74, 8'h6B, 8'h72, 8'h75};

  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} state_t;

  logic [1:0]    clk_sync_reg;
  logic [1:0]    data_sync_reg;
  logic [FW-1:0] filt_cnt_reg;
  logic          filt_clk_reg;
  logic          fall_reg;
  logic          fall_data_reg;
  logic [3:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic          parity_reg;
  logic [TW-1:0] idle_cnt_reg;
  logic          byte_strobe_reg;
  logic [7:0]    byte_reg;
  logic          err_strobe_reg;
  state_t        state_reg, state_next;
  logic          is_make, is_break, is_ext;
  logic          arrow_held_reg [4];
  logic          enter_held_reg;
  logic          space_held_reg;
  logic [15:0]   keycode_reg;
  logic          start_pressed_reg;
  logic          space_pressed_reg;
  logic          frame_err_reg;

  // Lines idle high, so the synchronizers and filtered clock come out of reset high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], PS2Clk};
      data_sync_reg <= {data_sync_reg[0], PS2Data};
    end
  end

  // Glitch filter: the level flips only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_cnt_reg  <= '0;
      filt_clk_reg  <= 1'b1;
      fall_reg      <= 1'b0;
      fall_data_reg <= 1'b1;
    end else begin
      fall_reg <= 1'b0;
      if (clk_sync_reg[1] != filt_clk_reg) begin
        if (filt_cnt_reg == FW'(FILTER_LEN - 1)) begin
          filt_clk_reg  <= clk_sync_reg[1];
          filt_cnt_reg  <= '0;
          fall_reg      <= ~clk_sync_reg[1];
          fall_data_reg <= data_sync_reg[1];
        end else begin
          filt_cnt_reg <= filt_cnt_reg + FW'(1);
        end
      end else begin
        filt_cnt_reg <= '0;
      end
    end
  end

  // Deframer: bit_cnt_reg 0 waits for a start bit, 1..8 data, 9 parity, 10 stop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_reg     <= '0;
      shift_reg       <= '0;
      parity_reg      <= 1'b0;
      idle_cnt_reg    <= '0;
      byte_strobe_reg <= 1'b0;
      byte_reg        <= '0;
      err_strobe_reg  <= 1'b0;
    end else begin
      byte_strobe_reg <= 1'b0;
      err_strobe_reg  <= 1'b0;
      if (fall_reg) begin
        idle_cnt_reg <= '0;
        if (bit_cnt_reg == 4'd0) begin
          if (!fall_data_reg) bit_cnt_reg <= 4'd1;
        end else if (bit_cnt_reg <= 4'd8) begin
          shift_reg   <= {fall_data_reg, shift_reg[7:1]};
          bit_cnt_reg <= bit_cnt_reg + 4'd1;
        end else if (bit_cnt_reg == 4'd9) begin
          parity_reg  <= fall_data_reg;
          bit_cnt_reg <= bit_cnt_reg + 4'd1;
        end else begin
          bit_cnt_reg <= '0;
          if (fall_data_reg && (^{shift_reg, parity_reg})) begin
            byte_strobe_reg <= 1'b1;
            byte_reg        <= shift_reg;
          end else begin
            err_strobe_reg <= 1'b1;
          end
        end
      end else if (bit_cnt_reg != 4'd0) begin
        if (idle_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt_reg    <= '0;
          idle_cnt_reg   <= '0;
          err_strobe_reg <= 1'b1;
        end else begin
          idle_cnt_reg <= idle_cnt_reg + TW'(1);
        end
      end else begin
        idle_cnt_reg <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    is_make    = 1'b0;
    is_break   = 1'b0;
    is_ext     = 1'b0;
    if (err_strobe_reg) begin
      state_next = ST_IDLE;
    end else if (byte_strobe_reg) begin
      case (state_reg)
        ST_IDLE: begin
          if (byte_reg == 8'hE0) state_next = ST_EXT;
          else if (byte_reg == 8'hF0) state_next = ST_BRK;
          else if (!(byte_reg inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) is_make = 1'b1;
        end
        ST_EXT: begin
          if (byte_reg == 8'hF0) state_next = ST_EXT_BRK;
          else if (byte_reg != 8'hE0) begin
            is_make    = 1'b1;
            is_ext     = 1'b1;
            state_next = ST_IDLE;
          end
        end
        ST_BRK: begin
          is_break   = 1'b1;
          state_next = ST_IDLE;
        end
        default: begin
          is_break   = 1'b1;
          is_ext     = 1'b1;
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_arrow
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        arrow_held_reg[gi] <= 1'b0;
      else if (is_ext && (is_make || is_break) && byte_reg == ARROW_CODES[gi])
        arrow_held_reg[gi] <= is_make;
    end
  end

  // Press pulses compare against the held flag before it is updated, so typematic repeats are silent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enter_held_reg    <= 1'b0;
      space_held_reg    <= 1'b0;
      keycode_reg       <= '0;
      start_pressed_reg <= 1'b0;
      space_pressed_reg <= 1'b0;
      frame_err_reg     <= 1'b0;
    end else begin
      frame_err_reg     <= err_strobe_reg;
      start_pressed_reg <= is_make && !is_ext && byte_reg == 8'h5A && !enter_held_reg;
      space_pressed_reg <= is_make && !is_ext && byte_reg == 8'h29 && !space_held_reg;
      if (is_make) keycode_reg <= {(is_ext ? 8'hE0 : 8'h00), byte_reg};
      if ((is_make || is_break) && !is_ext) begin
        if (byte_reg == 8'h5A) enter_held_reg <= is_make;
        if (byte_reg == 8'h29) space_held_reg <= is_make;
      end
    end
  end

  assign key_up        = arrow_held_reg[0];
  assign key_down      = arrow_held_reg[1];
  assign key_left      = arrow_held_reg[2];
  assign key_right     = arrow_held_reg[3];
  assign space_held    = space_held_reg;
  assign start_pressed = start_pressed_reg;
  assign space_pressed = space_pressed_reg;
  assign keycode       = keycode_reg;
  assign frame_err     = frame_err_reg;

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
Upstream input stage for the game controller. Receives raw PS/2 clock/data from the Basys3 USB-HID bridge, deframes scan-code bytes, and resolves E0/F0 prefixes into held-key flags. Produces clean one-cycle start/space pulses for the game-state machine and held arrow flags for player movement. Typematic repeats never re-trigger a pulse.

Parameters:
FILTER_LEN, 8, consecutive equal samples required before a synchronized ps2_clk level change is accepted.
TIMEOUT_CYCLES, 200000, idle clk cycles (2 ms at 100 MHz) mid-frame before the partial frame is aborted.

Ports:
clk  in  1  system clock, 100 MHz
reset_n  in  1  asynchronous active-low reset
PS2Clk  in  1  raw PS/2 clock, asynchronous
PS2Data  in  1  raw PS/2 data, asynchronous
key_up  out  1  up arrow (E0 75) held
key_down  out  1  down arrow (E0 72) held
key_left  out  1  left arrow (E0 6B) held
key_right  out  1  right arrow (E0 74) held
space_held  out  1  space (29) held
start_pressed  out  1  one-cycle pulse on enter (5A) make, not previously held
space_pressed  out  1  one-cycle pulse on space make, not previously held
keycode  out  16  last make code: {8'hE0 if extended else 8'h00, code}
frame_err  out  1  one-cycle pulse on parity/stop error or timeout

Behaviour:
- Reset (async, reset_n low): all outputs 0, keycode 16'h0000, decode FSM IDLE, bit counter 0, enter-held flag 0. Release is synchronous to clk.
- Input conditioning: PS2Clk and PS2Data each pass through a 2-FF synchronizer. Filtered clock changes level only after FILTER_LEN consecutive equal synchronized samples. Data is sampled on the filtered clock's falling edge.
- Frame: 11 bits; start 0, 8 data LSB first, odd parity, stop 1.
  - Start bit sampled 1: ignored, counter stays 0.
  - Parity or stop error: byte discarded, frame_err pulse, decode FSM forced to IDLE.
- Timeout: counter nonzero and no falling edge for TIMEOUT_CYCLES: counter cleared, FSM to IDLE, frame_err pulse.
- Byte strobe is internal and asserted for 1 cycle on the clk after the stop-bit falling edge. All flag/pulse/keycode updates are registered on the following edge. Latency: 2 clk from filtered stop-bit fall.
- Decode FSM: IDLE, EXT, BRK, EXT_BRK.
  - IDLE: E0 goes to EXT; F0 goes to BRK; FA/AA/EE/FE/00/FF are ignored and stay in IDLE; any other byte is a non-extended make, then IDLE.
  - EXT: F0 goes to EXT_BRK; E0 stays in EXT; other byte is an extended make, then IDLE.
  - BRK: byte is a non-extended break, then IDLE.
  - EXT_BRK: byte is an extended break, then IDLE.
- Make:
  - Sets the matching held flag.
  - keycode is updated for every make, mapped or not.
  - start_pressed/space_pressed pulse only if the key's held flag was 0 the cycle before. Typematic repeat makes give no pulse.
- Break: clears the matching held flag. A break of a non-held or unmapped key has no effect. Extended and non-extended codes are distinct: 75 without E0 (keypad 8) does not drive key_up.
- Pulses are high exactly 1 clk. Two strobes cannot fall in adjacent cycles, so pulses never merge.
- Pause sequence (E1 …) is treated as unmapped makes/breaks: no flag or pulse changes, keycode updates.

Test Plan:
- Reset: hold reset_n low mid-frame (after 5 bits), release, send frame 5A → all flags 0 during reset; after release exactly one start_pressed pulse, keycode=16'h005A; the partial frame does not corrupt it.
- Space typematic: send 29,29,29,F0,29 → one space_pressed pulse, 2 clk after first stop-bit fall; space_held 1 from first byte until the F0 29 pair completes, then 0.
- Arrows: E0 75, E0 6B, E0 F0 75 → key_up rises; key_left rises with key_up still 1; key_up falls, key_left stays 1; keycode=16'hE06B; plain 75 never sets key_up.
- Parity error: send 29 with even parity → frame_err 1 cycle, no space_pressed, FSM IDLE (next F0 29 treated as a fresh break).
- Timeout: send 4 bits, stall > TIMEOUT_CYCLES (override to 1000), then full frame 5A → frame_err pulse at timeout, then clean start_pressed.
- Glitch filter: 3-cycle low pulse on PS2Clk with FILTER_LEN=8 → no bit sampled; bit counter unchanged.
